// File: rtl/mixer_bus.sv
// mixer_bus: N-channel gain/mute/solo summing mixer with a 3-cycle pipeline and saturating output.
// Define MIXER_RAMP_EN to step each channel gain by one unit per frame instead of jumping.
module mixer_bus #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int VOL_BITS  = 4,
    parameter int OUT_WIDTH = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          valid_in,
    input  logic [CHANNELS*WIDTH-1:0]     data_dry,
    input  logic [CHANNELS*VOL_BITS-1:0]  volume,
    input  logic [CHANNELS-1:0]           mute,
    input  logic [CHANNELS-1:0]           solo,
    input  logic                          clip_clr,
    output logic signed [OUT_WIDTH-1:0]   data_wet,
    output logic                          valid_out,
    output logic                          clip
);
    localparam int PW = WIDTH + VOL_BITS + 1;
    localparam int SW = PW + $clog2(CHANNELS);
    localparam int CW = (SW > OUT_WIDTH ? SW : OUT_WIDTH) + 1;
    localparam logic signed [CW-1:0] MAX_V = {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [CW-1:0] MIN_V = ~MAX_V;

    logic [VOL_BITS-1:0]   t_w [CHANNELS];
    logic [VOL_BITS-1:0]   g_q [CHANNELS];
    logic [VOL_BITS-1:0]   g_d [CHANNELS];
    logic signed [PW-1:0]  p_q [CHANNELS];
    logic signed [PW-1:0]  p_d [CHANNELS];
    logic signed [SW-1:0]  sum_q, sum_d;
    logic signed [CW-1:0]  s_w;
    logic signed [OUT_WIDTH-1:0] wet_d;
    logic                  v1_q, v2_q, solo_any, hit;

    assign solo_any = |solo;

    // Products use the gain held before this frame's update; the new gain applies to the next frame.
    always_comb begin
        sum_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            t_w[c] = (solo_any ? solo[c] : !mute[c]) ? volume[c*VOL_BITS +: VOL_BITS] : '0;
`ifdef MIXER_RAMP_EN
            g_d[c] = g_q[c] < t_w[c] ? g_q[c] + VOL_BITS'(1) :
                     g_q[c] > t_w[c] ? g_q[c] - VOL_BITS'(1) : g_q[c];
`else
            g_d[c] = t_w[c];
`endif
            p_d[c] = PW'($signed(data_dry[c*WIDTH +: WIDTH])) * PW'($signed({1'b0, g_q[c]}));
            sum_d  = sum_d + SW'(p_q[c]);
        end
    end

    always_comb begin
        s_w   = CW'(sum_q >>> (VOL_BITS-1));
        hit   = (s_w > MAX_V) || (s_w < MIN_V);
        wet_d = s_w > MAX_V ? MAX_V[OUT_WIDTH-1:0] :
                s_w < MIN_V ? MIN_V[OUT_WIDTH-1:0] : s_w[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int c = 0; c < CHANNELS; c++) g_q[c] <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            valid_out <= 1'b0;
            data_wet  <= '0;
            clip      <= 1'b0;
        end else begin
            if (valid_in) begin
                g_q <= g_d;
                p_q <= p_d;
            end
            v1_q      <= valid_in;
            v2_q      <= v1_q;
            sum_q     <= sum_d;
            valid_out <= v2_q;
            if (v2_q) data_wet <= wet_d;
            clip <= (v2_q && hit) || (clip && !clip_clr);
        end
    end
endmodule

// File: tb/tb_mixer_bus.sv
// tb_mixer_bus: directed self-checking bench for mixer_bus (default parameters).
// Expectations adapt when MIXER_RAMP_EN is defined.
module tb_mixer_bus;
`ifdef MIXER_RAMP_EN
    localparam int SETTLE = 17;
    localparam bit RAMP = 1'b1;
`else
    localparam int SETTLE = 2;
    localparam bit RAMP = 1'b0;
`endif
    logic clk_in = 1'b0;
    logic rst_in, valid_in, clip_clr;
    logic [63:0] data_dry;
    logic [15:0] volume;
    logic [3:0] mute, solo;
    logic signed [15:0] data_wet;
    logic valid_out, clip;
    int n_checks = 0;
    int n_fail = 0;

    mixer_bus dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .data_dry(data_dry),
        .volume(volume), .mute(mute), .solo(solo), .clip_clr(clip_clr),
        .data_wet(data_wet), .valid_out(valid_out), .clip(clip)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [63:0] pack(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; valid_in = 1'b0; clip_clr = 1'b0;
        step(); step();
        rst_in = 1'b0;
    endtask

    // One isolated frame; returns the output observed 3 edges later and whether valid_out stayed low before it.
    task automatic frame(input logic [63:0] d, input logic [15:0] vol, input logic [3:0] m, input logic [3:0] s,
                         output logic signed [15:0] w, output logic vo, output logic lat_ok);
        data_dry = d; volume = vol; mute = m; solo = s; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        lat_ok = !valid_out;
        step();
        lat_ok = lat_ok && !valid_out;
        step();
        w = data_wet; vo = valid_out;
    endtask

    task automatic settle(input logic [63:0] d, input logic [15:0] vol, input logic [3:0] m, input logic [3:0] s,
                          output logic signed [15:0] w);
        logic vo, lat;
        for (int k = 0; k < SETTLE; k++) frame(d, vol, m, s, w, vo, lat);
    endtask

    task automatic test_reset();
        rst_in = 1'b1; valid_in = 1'b1; clip_clr = 1'b0;
        data_dry = pack(1000, 1000, 1000, 1000); volume = 16'h8888; mute = 4'h0; solo = 4'h0;
        step(); step(); step();
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_checks++; if (data_wet !== 16'sd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", data_wet); end
        n_checks++; if (clip !== 1'b0) begin n_fail++; $display("FAIL reset_clip: got %b want 0", clip); end
        rst_in = 1'b0; valid_in = 1'b0;
        step(); step(); step();
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_discard: got %b want 0", valid_out); end
    endtask

    task automatic test_unity();
        logic signed [15:0] w;
        logic vo, lat;
        do_reset();
        frame(pack(1000, 0, 0, 0), 16'h8888, 4'h0, 4'h0, w, vo, lat);
        n_checks++; if (vo !== 1'b1) begin n_fail++; $display("FAIL unity_valid: got %b want 1", vo); end
        n_checks++; if (lat !== 1'b1) begin n_fail++; $display("FAIL unity_latency: early valid_out seen"); end
        n_checks++; if (w !== 16'sd0) begin n_fail++; $display("FAIL unity_first: got %0d want 0", w); end
        settle(pack(1000, 0, 0, 0), 16'h8888, 4'h0, 4'h0, w);
        n_checks++; if (w !== 16'sd1000) begin n_fail++; $display("FAIL unity_pass: got %0d want 1000", w); end
        n_checks++; if (clip !== 1'b0) begin n_fail++; $display("FAIL unity_clip: got %b want 0", clip); end
        step();
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL unity_valid_drop: got %b want 0", valid_out); end
        n_checks++; if (data_wet !== 16'sd1000) begin n_fail++; $display("FAIL unity_hold: got %0d want 1000", data_wet); end
    endtask

    task automatic test_saturation();
        logic signed [15:0] w;
        logic vo, lat;
        settle(pack(16000, 16000, 16000, 16000), 16'h8888, 4'h0, 4'h0, w);
        n_checks++; if (w !== 16'sd32767) begin n_fail++; $display("FAIL sat_pos: got %0d want 32767", w); end
        n_checks++; if (clip !== 1'b1) begin n_fail++; $display("FAIL sat_clip_set: got %b want 1", clip); end
        settle(pack(-16000, -16000, -16000, -16000), 16'h8888, 4'h0, 4'h0, w);
        n_checks++; if (w !== -16'sd32768) begin n_fail++; $display("FAIL sat_neg: got %0d want -32768", w); end
        n_checks++; if (clip !== 1'b1) begin n_fail++; $display("FAIL sat_clip_sticky: got %b want 1", clip); end
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        n_checks++; if (clip !== 1'b0) begin n_fail++; $display("FAIL clip_clear: got %b want 0", clip); end
        settle(pack(8192, 8192, 8192, 8191), 16'h8888, 4'h0, 4'h0, w);
        n_checks++; if (w !== 16'sd32767) begin n_fail++; $display("FAIL edge_pos: got %0d want 32767", w); end
        n_checks++; if (clip !== 1'b0) begin n_fail++; $display("FAIL edge_pos_clip: got %b want 0", clip); end
        settle(pack(-8192, -8192, -8192, -8192), 16'h8888, 4'h0, 4'h0, w);
        n_checks++; if (w !== -16'sd32768) begin n_fail++; $display("FAIL edge_neg: got %0d want -32768", w); end
        n_checks++; if (clip !== 1'b0) begin n_fail++; $display("FAIL edge_neg_clip: got %b want 0", clip); end
        clip_clr = 1'b1;
        frame(pack(16000, 16000, 16000, 16000), 16'h8888, 4'h0, 4'h0, w, vo, lat);
        n_checks++; if (clip !== 1'b1) begin n_fail++; $display("FAIL clip_set_wins: got %b want 1", clip); end
        step();
        n_checks++; if (clip !== 1'b0) begin n_fail++; $display("FAIL clip_clr_after: got %b want 0", clip); end
        clip_clr = 1'b0;
    endtask

    task automatic test_mute_solo();
        logic signed [15:0] w;
        settle(pack(100, 200, 300, 400), 16'h8888, 4'b0001, 4'b0000, w);
        n_checks++; if (w !== 16'sd900) begin n_fail++; $display("FAIL mute: got %0d want 900", w); end
        settle(pack(100, 200, 300, 400), 16'h8888, 4'b0001, 4'b0101, w);
        n_checks++; if (w !== 16'sd400) begin n_fail++; $display("FAIL solo_over_mute: got %0d want 400", w); end
        settle(pack(100, 200, 300, 400), 16'h8888, 4'b1111, 4'b0000, w);
        n_checks++; if (w !== 16'sd0) begin n_fail++; $display("FAIL mute_all: got %0d want 0", w); end
        settle(pack(100, 200, 300, 400), 16'h8888, 4'b1111, 4'b1000, w);
        n_checks++; if (w !== 16'sd400) begin n_fail++; $display("FAIL solo_ch3: got %0d want 400", w); end
    endtask

    task automatic test_gain();
        logic signed [15:0] w;
        settle(pack(0, 1000, 0, 0), 16'h0040, 4'h0, 4'h0, w);
        n_checks++; if (w !== 16'sd500) begin n_fail++; $display("FAIL gain4: got %0d want 500", w); end
        settle(pack(0, 1000, 0, 0), 16'h00F0, 4'h0, 4'h0, w);
        n_checks++; if (w !== 16'sd1875) begin n_fail++; $display("FAIL gain15: got %0d want 1875", w); end
        settle(pack(0, 1000, 0, 0), 16'h0000, 4'h0, 4'h0, w);
        n_checks++; if (w !== 16'sd0) begin n_fail++; $display("FAIL gain0: got %0d want 0", w); end
        settle(pack(0, -1001, 0, 0), 16'h00F0, 4'h0, 4'h0, w);
        n_checks++; if (w !== -16'sd1877) begin n_fail++; $display("FAIL gain_neg_floor: got %0d want -1877", w); end
    endtask

    task automatic test_gain_step();
        logic signed [15:0] w, e;
        logic vo, lat;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            frame(pack(800, 0, 0, 0), 16'h0008, 4'h0, 4'h0, w, vo, lat);
            e = RAMP ? 16'(100 * (k < 8 ? k : 8)) : (k == 0 ? 16'sd0 : 16'sd800);
            n_checks++; if (w !== e) begin n_fail++; $display("FAIL fade_in[%0d]: got %0d want %0d", k, w, e); end
        end
        for (int k = 0; k < 9; k++) begin
            frame(pack(800, 0, 0, 0), 16'h0008, 4'b0001, 4'h0, w, vo, lat);
            e = RAMP ? 16'(800 - 100 * k) : (k == 0 ? 16'sd800 : 16'sd0);
            n_checks++; if (w !== e) begin n_fail++; $display("FAIL fade_out[%0d]: got %0d want %0d", k, w, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] w;
        settle(pack(10, 0, 0, 0), 16'h8888, 4'h0, 4'h0, w);
        data_dry = pack(10, 0, 0, 0); valid_in = 1'b1;
        step();
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_lat0: got %b want 0", valid_out); end
        data_dry = pack(20, 0, 0, 0);
        step();
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_lat1: got %b want 0", valid_out); end
        data_dry = pack(30, 0, 0, 0);
        step();
        valid_in = 1'b0;
        n_checks++; if (valid_out !== 1'b1 || data_wet !== 16'sd10) begin n_fail++; $display("FAIL b2b_0: got %b/%0d want 1/10", valid_out, data_wet); end
        step();
        n_checks++; if (valid_out !== 1'b1 || data_wet !== 16'sd20) begin n_fail++; $display("FAIL b2b_1: got %b/%0d want 1/20", valid_out, data_wet); end
        step();
        n_checks++; if (valid_out !== 1'b1 || data_wet !== 16'sd30) begin n_fail++; $display("FAIL b2b_2: got %b/%0d want 1/30", valid_out, data_wet); end
        step();
        n_checks++; if (valid_out !== 1'b0 || data_wet !== 16'sd30) begin n_fail++; $display("FAIL b2b_end: got %b/%0d want 0/30", valid_out, data_wet); end
    endtask

    task automatic test_reset_throughput();
        data_dry = pack(800, 0, 0, 0); volume = 16'h0008; mute = 4'h0; solo = 4'h0; valid_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rst_in = (i == 10);
            step();
            if (i == 9) begin
                n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL rt_pre_valid: got %b want 1", valid_out); end
            end
            if (i >= 10 && i <= 12) begin
                n_checks++; if (valid_out !== 1'b0 || data_wet !== 16'sd0) begin n_fail++; $display("FAIL rt_flush[%0d]: got %b/%0d want 0/0", i, valid_out, data_wet); end
            end
            if (i == 13) begin
                n_checks++; if (valid_out !== 1'b1 || data_wet !== 16'sd0) begin n_fail++; $display("FAIL rt_first: got %b/%0d want 1/0", valid_out, data_wet); end
            end
            if (i == 14) begin
                n_checks++; if (data_wet !== (RAMP ? 16'sd100 : 16'sd800)) begin n_fail++; $display("FAIL rt_second: got %0d want %0d", data_wet, RAMP ? 100 : 800); end
            end
            if (i == 15) begin
                n_checks++; if (data_wet !== (RAMP ? 16'sd200 : 16'sd800)) begin n_fail++; $display("FAIL rt_third: got %0d want %0d", data_wet, RAMP ? 200 : 800); end
            end
        end
        rst_in = 1'b0; valid_in = 1'b0;
        step(); step(); step(); step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0; valid_in = 1'b0; clip_clr = 1'b0;
        data_dry = '0; volume = '0; mute = '0; solo = '0;
        test_reset();
        test_unity();
        test_saturation();
        test_mute_solo();
        test_gain();
        test_gain_step();
        test_back_to_back();
        test_reset_throughput();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
